mem_responder: RTL

//  Memory-side responder for the LC-3b word memory interface (mem_read/mem_write/mem_address/
//  mem_wdata/mem_byte_enable -> mem_resp/mem_rdata). It serves requests from the pipeline's memory

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Fixed-latency word-memory responder for the LC-3b memory interface.
// Captures one request, answers it LATENCY cycles later, and honours aborts and resets.
module mem_responder #(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned WORD_BITS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned DEPTH = 1 << WORD_BITS;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   idx_q, idx_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [1:0]             be_q, be_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   resp_q, resp_d;
  logic [15:0]            rdata_q, rdata_d;

  logic [15:0]            mem_q [DEPTH];

  logic                   req_c;
  logic                   enter_resp_c;
  logic                   we_c;
  logic [WORD_BITS-1:0]   eff_idx_c;
  logic [15:0]            eff_wdata_c;
  logic [1:0]             eff_be_c;
  logic                   eff_rd_c;
  logic                   eff_wr_c;
  logic [15:0]            old_word_c;
  logic [15:0]            merged_c;
  logic                   unused_addr_c;

  assign req_c         = mem_read | mem_write;
  assign unused_addr_c = ^{mem_address[15:WORD_BITS+1], mem_address[0]};

  // In IDLE the live request is the one being accepted; afterwards only captured values count.
  always_comb begin
    eff_idx_c   = idx_q;
    eff_wdata_c = wdata_q;
    eff_be_c    = be_q;
    eff_rd_c    = rd_q;
    eff_wr_c    = wr_q;
    if (state_q == IDLE) begin
      eff_idx_c   = mem_address[WORD_BITS:1];
      eff_wdata_c = mem_wdata;
      eff_be_c    = mem_byte_enable;
      eff_rd_c    = mem_read;
      eff_wr_c    = mem_write;
    end
    old_word_c = mem_q[eff_idx_c];
    merged_c   = {eff_be_c[1] ? eff_wdata_c[15:8] : old_word_c[15:8],
                  eff_be_c[0] ? eff_wdata_c[7:0]  : old_word_c[7:0]};
  end

  // Next-state, capture and response logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    resp_d       = 1'b0;
    enter_resp_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          idx_d   = mem_address[WORD_BITS:1];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          rd_d    = mem_read;
          wr_d    = mem_write;
          if (LATENCY == 1) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (!req_c) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    resp_d = enter_resp_c;
    // A combined read+write returns the word as it will be after the merge.
    if (enter_resp_c && eff_rd_c) begin
      rdata_d = eff_wr_c ? merged_c : old_word_c;
    end
  end

  assign we_c = enter_resp_c & eff_wr_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[eff_idx_c] <= merged_c;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

endmodule
